// File: rtl/instr_fetch_unit.sv
// Program store + PC + 2-entry prefetch queue; jumps (opcode 111) resolve here and never leave the block.
// First word valid two edges after run rises; taken jumps cost two bubbles; head holds while instr_ready=0.
module instr_fetch_unit #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  output logic [31:0]   instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic [2:0]    status,
  input  logic          status_ready,
  output logic [AW-1:0] pc_out,
  output logic          done
);

  localparam logic [AW:0]  PC_END  = (AW+1)'(DEPTH);
  localparam logic [25:0]  TGT_END = 26'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_vld;
  logic [AW:0]   pc;

  logic [31:0]   q_word [2];
  logic [AW-1:0] q_addr [2];
  logic [1:0]    q_cnt;

  logic          head_vld;
  logic          is_jump;
  logic          taken;
  logic          resolve;
  logic          flush;
  logic          tgt_oor;
  logic          pop;
  logic          push;
  logic          issue;
  logic          end_of_prog;
  logic [1:0]    occ_eff;
  logic [1:0]    q_cnt_nxt;

  always_comb begin
    head_vld    = (q_cnt != 2'd0);
    is_jump     = head_vld && (q_word[0][31:29] == 3'b111);
    instr_valid = head_vld && !is_jump;
    instr_out   = head_vld ? q_word[0] : 32'h0;
    pc_out      = head_vld ? q_addr[0] : '0;

    case (q_word[0][28:26])
      3'b001:  taken = status[0];
      3'b010:  taken = status[1];
      3'b100:  taken = status[2];
      default: taken = 1'b1;
    endcase

    resolve = is_jump && status_ready;
    flush   = resolve && taken;
    tgt_oor = (q_word[0][25:0] >= TGT_END);
    pop     = (instr_valid && instr_ready) || (resolve && !taken);
    push    = rd_vld && !flush;

    // Occupancy after this cycle's pop, so a draining queue keeps one read in flight every cycle.
    occ_eff   = q_cnt - {1'b0, pop};
    q_cnt_nxt = occ_eff + {1'b0, push};
    issue     = run && !done && (pc < PC_END) && !flush &&
                ((occ_eff + {1'b0, rd_vld}) < 2'd2);

    end_of_prog = (pc == PC_END) && (q_cnt == 2'd0) && !rd_vld;
  end

  // Program store keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (prog_we && !run && ({1'b0, prog_addr} < PC_END))
      mem[prog_addr] <= prog_data;
    if (issue)
      rd_data <= mem[pc[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      rd_vld    <= 1'b0;
      rd_addr   <= '0;
      q_cnt     <= 2'd0;
      q_word[0] <= 32'h0;
      q_word[1] <= 32'h0;
      q_addr[0] <= '0;
      q_addr[1] <= '0;
      done      <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        rd_addr <= pc[AW-1:0];
        pc      <= pc + {{AW{1'b0}}, 1'b1};
      end

      if (flush) begin
        // The read landing this edge belongs to the abandoned path and is dropped.
        q_cnt <= 2'd0;
        pc    <= {1'b0, q_word[0][AW-1:0]};
        if (tgt_oor)
          done <= 1'b1;
      end else begin
        q_cnt <= q_cnt_nxt;
        if (pop) begin
          q_word[0] <= q_word[1];
          q_addr[0] <= q_addr[1];
        end
        if (push) begin
          q_word[occ_eff[0]] <= rd_data;
          q_addr[occ_eff[0]] <= rd_addr;
        end
      end

      if (end_of_prog)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, jumps, status stall, out-of-range jump, async reset.
module tb_instr_fetch_unit;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    status;
  logic          status_ready;
  logic [AW-1:0] pc_out;
  logic          done;

  int checks   = 0;
  int failures = 0;

  int            got_cyc[$];
  logic [AW-1:0] got_pc[$];
  logic [31:0]   got_word[$];
  int            done_cyc;
  int            frozen_bad;

  instr_fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .status(status), .status_ready(status_ready),
    .pc_out(pc_out), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mov(input int i);
    return 32'(i) * 32'h0001_0101;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0; prog_we = 1'b0;
    status = 3'b000; status_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    instr_ready = 1'b1;
    run = 1'b1;
    step();
    step();
  endtask

  // Records accepted transfers as (cycle, pc, word); cycle 0 is two edges after run rose.
  task automatic capture(input int k, input int sr_from, input int lo_s, input int lo_len);
    logic          rdy;
    logic          held;
    logic [AW-1:0] last_pc;
    logic [31:0]   last_w;
    got_cyc.delete(); got_pc.delete(); got_word.delete();
    done_cyc = -1; frozen_bad = 0; held = 1'b0; last_pc = '0; last_w = 32'h0;
    for (int c = 0; c < k; c++) begin
      rdy = !(c >= lo_s && c < lo_s + lo_len);
      if (held && (!instr_valid || pc_out !== last_pc || instr_out !== last_w))
        frozen_bad++;
      if (done === 1'b1 && done_cyc < 0)
        done_cyc = c;
      if (instr_valid === 1'b1 && rdy) begin
        got_cyc.push_back(c); got_pc.push_back(pc_out); got_word.push_back(instr_out);
      end
      held = (instr_valid === 1'b1) && !rdy;
      last_pc = pc_out; last_w = instr_out;
      instr_ready = rdy;
      status_ready = (c >= sr_from);
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = 32'h0; status = 3'b000; status_ready = 1'b1;
    #2;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr_out); end
    checks++; if (pc_out !== '0) begin failures++; $display("FAIL reset_pc: got %0d want 0", pc_out); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word(i, mov(i));
    start_run();
    capture(35, 0, 99, 0);
    checks++;
    if (got_cyc.size() != DEPTH) begin failures++; $display("FAIL stream_count: got %0d want %0d", got_cyc.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (i >= got_cyc.size()) begin
        failures++; $display("FAIL stream[%0d]: missing, want cyc=%0d pc=%0d", i, i, i);
      end else if (got_cyc[i] != i || got_pc[i] !== AW'(i) || got_word[i] !== mov(i)) begin
        failures++;
        $display("FAIL stream[%0d]: got cyc=%0d pc=%0d word=%h, want cyc=%0d pc=%0d word=%h",
                 i, got_cyc[i], got_pc[i], got_word[i], i, i, mov(i));
      end
    end
    checks++; if (done_cyc != 33) begin failures++; $display("FAIL stream_done_cycle: got %0d want 33", done_cyc); end
    checks++;
    if (instr_valid !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL stream_after_done: got valid=%b done=%b want valid=0 done=1", instr_valid, done);
    end
  endtask

  task automatic test_backpressure();
    int ec[7] = '{0, 1, 2, 8, 9, 10, 11};
    int ep[7] = '{0, 1, 2, 3, 4, 5, 6};
    do_reset();
    start_run();
    capture(12, 0, 3, 5);
    checks++;
    if (got_cyc.size() != 7) begin failures++; $display("FAIL bp_count: got %0d want 7", got_cyc.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= got_cyc.size()) begin
        failures++; $display("FAIL bp[%0d]: missing, want cyc=%0d pc=%0d", i, ec[i], ep[i]);
      end else if (got_cyc[i] != ec[i] || got_pc[i] !== AW'(ep[i]) || got_word[i] !== mov(ep[i])) begin
        failures++;
        $display("FAIL bp[%0d]: got cyc=%0d pc=%0d word=%h, want cyc=%0d pc=%0d word=%h",
                 i, got_cyc[i], got_pc[i], got_word[i], ec[i], ep[i], mov(ep[i]));
      end
    end
    checks++; if (frozen_bad != 0) begin failures++; $display("FAIL bp_frozen: got %0d changes want 0", frozen_bad); end
  endtask

  task automatic test_jump_taken();
    int ec[7] = '{0, 1, 2, 6, 7, 11, 12};
    int ep[7] = '{0, 1, 2, 1, 2, 1, 2};
    do_reset();
    load_word(3, 32'hE400_0001);
    status = 3'b001;
    start_run();
    capture(13, 0, 99, 0);
    checks++;
    if (got_cyc.size() != 7) begin failures++; $display("FAIL taken_count: got %0d want 7", got_cyc.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= got_cyc.size()) begin
        failures++; $display("FAIL taken[%0d]: missing, want cyc=%0d pc=%0d", i, ec[i], ep[i]);
      end else if (got_cyc[i] != ec[i] || got_pc[i] !== AW'(ep[i]) || got_word[i] !== mov(ep[i])) begin
        failures++;
        $display("FAIL taken[%0d]: got cyc=%0d pc=%0d word=%h, want cyc=%0d pc=%0d word=%h",
                 i, got_cyc[i], got_pc[i], got_word[i], ec[i], ep[i], mov(ep[i]));
      end
    end
  endtask

  task automatic test_jump_not_taken();
    int ec[7] = '{0, 1, 2, 4, 5, 6, 7};
    int ep[7] = '{0, 1, 2, 4, 5, 6, 7};
    do_reset();
    status = 3'b000;
    start_run();
    capture(8, 0, 99, 0);
    checks++;
    if (got_cyc.size() != 7) begin failures++; $display("FAIL ntaken_count: got %0d want 7", got_cyc.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= got_cyc.size()) begin
        failures++; $display("FAIL ntaken[%0d]: missing, want cyc=%0d pc=%0d", i, ec[i], ep[i]);
      end else if (got_cyc[i] != ec[i] || got_pc[i] !== AW'(ep[i]) || got_word[i] !== mov(ep[i])) begin
        failures++;
        $display("FAIL ntaken[%0d]: got cyc=%0d pc=%0d word=%h, want cyc=%0d pc=%0d word=%h",
                 i, got_cyc[i], got_pc[i], got_word[i], ec[i], ep[i], mov(ep[i]));
      end
    end
  endtask

  task automatic test_status_stall();
    int ec[6] = '{0, 1, 2, 8, 9, 10};
    int ep[6] = '{0, 1, 2, 4, 5, 6};
    do_reset();
    status = 3'b000;
    start_run();
    capture(11, 7, 99, 0);
    checks++;
    if (got_cyc.size() != 6) begin failures++; $display("FAIL stall_count: got %0d want 6", got_cyc.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_cyc.size()) begin
        failures++; $display("FAIL stall[%0d]: missing, want cyc=%0d pc=%0d", i, ec[i], ep[i]);
      end else if (got_cyc[i] != ec[i] || got_pc[i] !== AW'(ep[i]) || got_word[i] !== mov(ep[i])) begin
        failures++;
        $display("FAIL stall[%0d]: got cyc=%0d pc=%0d word=%h, want cyc=%0d pc=%0d word=%h",
                 i, got_cyc[i], got_pc[i], got_word[i], ec[i], ep[i], mov(ep[i]));
      end
    end
  endtask

  task automatic test_jump_out_of_range();
    do_reset();
    load_word(3, 32'hE000_0028);
    start_run();
    capture(10, 0, 99, 0);
    checks++;
    if (got_cyc.size() != 3) begin failures++; $display("FAIL oor_count: got %0d want 3", got_cyc.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_cyc.size()) begin
        failures++; $display("FAIL oor[%0d]: missing, want cyc=%0d pc=%0d", i, i, i);
      end else if (got_cyc[i] != i || got_pc[i] !== AW'(i) || got_word[i] !== mov(i)) begin
        failures++;
        $display("FAIL oor[%0d]: got cyc=%0d pc=%0d word=%h, want cyc=%0d pc=%0d word=%h",
                 i, got_cyc[i], got_pc[i], got_word[i], i, i, mov(i));
      end
    end
    checks++; if (done_cyc != 4) begin failures++; $display("FAIL oor_done_cycle: got %0d want 4", done_cyc); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL oor_valid_after: got %b want 0", instr_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_done_cleared: got %b want 0", done); end
    load_word(3, mov(3));
    instr_ready = 1'b0;
    run = 1'b1;
    prog_we = 1'b1; prog_addr = '0; prog_data = 32'hE000_0028;
    step();
    prog_we = 1'b0;
    step();
    instr_ready = 1'b1;
    step();
    step();
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== AW'(2)) begin
      failures++; $display("FAIL mid_pre_reset: got valid=%b pc=%0d want valid=1 pc=2", instr_valid, pc_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({instr_valid, pc_out, instr_out, done} !== '0) begin
      failures++;
      $display("FAIL mid_async_reset: got valid=%b pc=%0d instr=%h done=%b want all 0",
               instr_valid, pc_out, instr_out, done);
    end
    #1 reset = 1'b0;
    step();
    step();
    capture(5, 0, 99, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_cyc.size()) begin
        failures++; $display("FAIL restart[%0d]: missing, want cyc=%0d pc=%0d", i, i, i);
      end else if (got_cyc[i] != i || got_pc[i] !== AW'(i) || got_word[i] !== mov(i)) begin
        failures++;
        $display("FAIL restart[%0d]: got cyc=%0d pc=%0d word=%h, want cyc=%0d pc=%0d word=%h",
                 i, got_cyc[i], got_pc[i], got_word[i], i, i, mov(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_taken();
    test_jump_not_taken();
    test_status_stall();
    test_jump_out_of_range();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
